// File: rtl/uart_tx_framer.sv
// UART transmit framer: takes one word over valid/ready and sends start, LSB-first data,
// optional parity and stop bit(s) on a registered serial line.
module uart_tx_framer #(
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    input  logic [3:0]  data_size,
    input  logic [13:0] bit_period,
    output logic        tx_ready,
    output logic        serial_out,
    output logic        tx_busy,
    output logic        tx_done
);

    // state  | meaning
    // IDLE   | line at mark, ready for a word
    // START  | driving the start bit (low)
    // DATA   | shifting out N data bits, LSB first
    // PARITY | driving the parity bit (only reached when PARITY_EN=1)
    // STOP   | driving STOP_BITS stop bits (high)
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic PAR_INV = (PARITY_ODD != 0);
    localparam logic TWO_STOP = (STOP_BITS == 2);

    state_t      state, state_nxt;
    logic [7:0]  shift_reg, shift_nxt;
    logic [3:0]  n_bits, n_bits_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [13:0] period, period_nxt;
    logic [13:0] cyc_cnt, cyc_cnt_nxt;
    logic        stop_cnt, stop_cnt_nxt;
    logic        parity_acc, parity_nxt;
    logic        line_nxt;
    logic        done_nxt;
    logic        strobe;
    logic        last_stop;
    logic [3:0]  n_clamp;
    logic [13:0] p_clamp;

    assign n_clamp   = (data_size == 4'd0) ? 4'd1 :
                       (data_size > 4'd8)  ? 4'd8 : data_size;
    assign p_clamp   = (bit_period < 14'd2) ? 14'd2 : bit_period;
    assign strobe    = (cyc_cnt == period);
    assign last_stop = TWO_STOP ? stop_cnt : 1'b1;

    assign tx_ready = (state == IDLE);
    assign tx_busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            n_bits     <= '0;
            bit_cnt    <= '0;
            period     <= '0;
            cyc_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_acc <= 1'b0;
            serial_out <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_reg  <= shift_nxt;
            n_bits     <= n_bits_nxt;
            bit_cnt    <= bit_cnt_nxt;
            period     <= period_nxt;
            cyc_cnt    <= cyc_cnt_nxt;
            stop_cnt   <= stop_cnt_nxt;
            parity_acc <= parity_nxt;
            serial_out <= line_nxt;
            tx_done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift_reg;
        n_bits_nxt   = n_bits;
        bit_cnt_nxt  = bit_cnt;
        period_nxt   = period;
        cyc_cnt_nxt  = strobe ? 14'd1 : cyc_cnt + 14'd1;
        stop_cnt_nxt = stop_cnt;
        parity_nxt   = parity_acc;
        line_nxt     = serial_out;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                cyc_cnt_nxt = '0;
                if (tx_valid) begin
                    state_nxt    = START;
                    shift_nxt    = tx_data;
                    n_bits_nxt   = n_clamp;
                    period_nxt   = p_clamp;
                    cyc_cnt_nxt  = 14'd1;
                    bit_cnt_nxt  = '0;
                    stop_cnt_nxt = 1'b0;
                    parity_nxt   = 1'b0;
                    line_nxt     = 1'b0;
                end
            end
            START: begin
                if (strobe) begin
                    state_nxt   = DATA;
                    line_nxt    = shift_reg[0];
                    parity_nxt  = shift_reg[0];
                    shift_nxt   = {1'b0, shift_reg[7:1]};
                    bit_cnt_nxt = 4'd1;
                end
            end
            DATA: begin
                if (strobe) begin
                    if (bit_cnt == n_bits) begin
                        if (PARITY_EN != 0) begin
                            state_nxt = PARITY;
                            line_nxt  = parity_acc ^ PAR_INV;
                        end else begin
                            state_nxt = STOP;
                            line_nxt  = 1'b1;
                        end
                    end else begin
                        line_nxt    = shift_reg[0];
                        parity_nxt  = parity_acc ^ shift_reg[0];
                        shift_nxt   = {1'b0, shift_reg[7:1]};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (strobe) begin
                    state_nxt = STOP;
                    line_nxt  = 1'b1;
                end
            end
            STOP: begin
                if (strobe) begin
                    // Landing in IDLE with done set lets a held tx_valid be accepted in the done cycle.
                    if (last_stop) begin
                        state_nxt    = IDLE;
                        done_nxt     = 1'b1;
                        cyc_cnt_nxt  = '0;
                        bit_cnt_nxt  = '0;
                        stop_cnt_nxt = 1'b0;
                    end else begin
                        stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: three configurations, frames predicted by a model into a
// queue at accept time and checked cycle by cycle as they appear on the line.
module tb_uart_tx_framer;

    typedef struct {
        logic [12:0] lvl;
        int          nb;
        int          p;
        int          acc;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [3:0]  data_size;
    logic [13:0] bit_period;
    logic [1:0]  sel;
    logic [2:0]  valid_v;
    logic        ready_v [3];
    logic        so_v    [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        ready_m, so_m, busy_m, done_m;

    int     cyc = 0;
    int     errors = 0;
    int     checks = 0;
    frame_t sb [$];
    bit     in_frame = 0;
    bit     done_next = 0;
    bit     after_done = 0;
    bit     stray_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign valid_v[0] = tx_valid && (sel == 2'd0);
    assign valid_v[1] = tx_valid && (sel == 2'd1);
    assign valid_v[2] = tx_valid && (sel == 2'd2);

    always_comb begin
        ready_m = ready_v[sel];
        so_m    = so_v[sel];
        busy_m  = busy_v[sel];
        done_m  = done_v[sel];
    end

    // 8N1
    uart_tx_framer #(.STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u_8n1 (
        .clk(clk), .rst(rst), .tx_valid(valid_v[0]), .tx_data(tx_data),
        .data_size(data_size), .bit_period(bit_period), .tx_ready(ready_v[0]),
        .serial_out(so_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));

    // even parity, two stop bits
    uart_tx_framer #(.STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) u_8e2 (
        .clk(clk), .rst(rst), .tx_valid(valid_v[1]), .tx_data(tx_data),
        .data_size(data_size), .bit_period(bit_period), .tx_ready(ready_v[1]),
        .serial_out(so_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));

    // odd parity, one stop bit
    uart_tx_framer #(.STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
        .clk(clk), .rst(rst), .tx_valid(valid_v[2]), .tx_data(tx_data),
        .data_size(data_size), .bit_period(bit_period), .tx_ready(ready_v[2]),
        .serial_out(so_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic frame_t model(input logic [7:0] d, input logic [3:0] sz,
                                     input logic [13:0] bp, input logic [1:0] s, input int acc);
        frame_t r;
        int     n;
        int     idx;
        int     pe;
        int     odd;
        int     stops;
        logic   par;
        pe    = (s == 2'd0) ? 0 : 1;
        odd   = (s == 2'd2) ? 1 : 0;
        stops = (s == 2'd1) ? 2 : 1;
        n     = (sz == 4'd0) ? 1 : (sz > 4'd8) ? 8 : int'(sz);
        r.p   = (bp < 14'd2) ? 2 : int'(bp);
        r.acc = acc;
        r.lvl = '0;
        par   = 1'b0;
        idx   = 1;
        for (int i = 0; i < n; i++) begin
            r.lvl[idx] = d[i];
            par        = par ^ d[i];
            idx++;
        end
        if (pe != 0) begin
            r.lvl[idx] = par ^ (odd != 0);
            idx++;
        end
        for (int i = 0; i < stops; i++) begin
            r.lvl[idx] = 1'b1;
            idx++;
        end
        r.nb = idx;
        return r;
    endfunction

    // Line monitor: pops the predicted frame on the start edge and checks every bit time.
    initial begin
        frame_t cur;
        int     bit_idx;
        int     cyc_in_bit;
        int     match;
        int     done_seen;
        int     hs_bad;
        cur = '{lvl: '0, nb: 0, p: 0, acc: 0};
        bit_idx = 0; cyc_in_bit = 0; match = 0; done_seen = 0; hs_bad = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                in_frame   = 0;
                done_next  = 0;
                after_done = 0;
            end else begin
                if (tx_valid && ready_m)
                    sb.push_back(model(tx_data, data_size, bit_period, sel, cyc));
                if (done_next) begin
                    check("tx_done", int'(done_m), 1);
                    check("ready_end", int'(ready_m), 1);
                    check("busy_end", int'(busy_m), 0);
                    check("done_cyc", cyc, cur.acc + 1 + cur.nb * cur.p);
                    done_next  = 0;
                    after_done = 1;
                end else begin
                    if (after_done) begin
                        check("done_width", int'(done_m), 0);
                        after_done = 0;
                    end
                    if (!in_frame && so_m == 1'b0) begin
                        if (sb.size() == 0) begin
                            if (!stray_seen) check("unexpected_start", 0, 1);
                            stray_seen = 1;
                        end else begin
                            cur = sb.pop_front();
                            check("start_lat", cyc, cur.acc + 1);
                            in_frame = 1;
                            bit_idx = 0; cyc_in_bit = 0; match = 0; done_seen = 0; hs_bad = 0;
                        end
                    end
                    if (in_frame) begin
                        if (done_m) done_seen++;
                        if (busy_m !== 1'b1 || ready_m !== 1'b0) hs_bad++;
                        if (so_m === cur.lvl[bit_idx]) match++;
                        cyc_in_bit++;
                        if (cyc_in_bit == cur.p) begin
                            check($sformatf("bit%0d", bit_idx), match, cur.p);
                            bit_idx++;
                            cyc_in_bit = 0;
                            match = 0;
                            if (bit_idx == cur.nb) begin
                                check("done_in_frame", done_seen, 0);
                                check("busy_in_frame", hs_bad, 0);
                                in_frame  = 0;
                                done_next = 1;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [3:0] sz, input logic [13:0] bp,
                        input bit keep);
        int n;
        @(posedge clk);
        #1;
        tx_data    = d;
        data_size  = sz;
        bit_period = bp;
        tx_valid   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_m && n < 2000);
        if (!ready_m) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((in_frame || done_next || after_done || sb.size() != 0) && n < 3000);
        if (n >= 3000) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int dones;
        int lows;
        rst        = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = '0;
        data_size  = 4'd8;
        bit_period = 14'd10;
        sel        = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_line", int'(so_m), 1);
        check("rst_ready", int'(ready_m), 1);
        check("rst_busy", int'(busy_m), 0);
        check("rst_done", int'(done_m), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        send(8'hA5, 4'd8, 14'd10, 0); wait_idle();
        send(8'hFF, 4'd5, 14'd10, 0); wait_idle();

        sel = 2'd1;
        send(8'h03, 4'd8, 14'd10, 0); wait_idle();
        send(8'h07, 4'd3, 14'd3, 0);  wait_idle();
        sel = 2'd2;
        send(8'h03, 4'd8, 14'd10, 0); wait_idle();
        send(8'h5B, 4'd6, 14'd4, 0);  wait_idle();

        sel = 2'd0;
        send(8'h3C, 4'd8, 14'd4, 1);
        send(8'hC3, 4'd8, 14'd4, 0);
        wait_idle();

        send(8'h5A, 4'd8, 14'd10, 0);
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_line", int'(so_m), 1);
        check("midrst_ready", int'(ready_m), 1);
        check("midrst_busy", int'(busy_m), 0);
        check("midrst_done", int'(done_m), 0);
        dones = 0;
        lows  = 0;
        repeat (150) begin
            @(negedge clk);
            if (done_m) dones++;
            if (!so_m) lows++;
        end
        check("midrst_no_done", dones, 0);
        check("midrst_line_idle", lows, 0);
        send(8'h96, 4'd8, 14'd10, 0); wait_idle();

        send(8'h01, 4'd0, 14'd0, 0); wait_idle();
        send(8'hB4, 4'd12, 14'd1, 0);
        tx_data    = 8'h00;
        data_size  = 4'd2;
        bit_period = 14'd50;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
